// File: rtl/ecdsa_project_wrapper.sv
// ECDSA coprocessor shell: AXI4-Lite CSR slave, a shared 1024-bit data RAM
// with host and core ports, and a core engine that increments one word.
module ecdsa_project_wrapper #(
    parameter int MEM_DEPTH = 1024
) (
    input  logic           clk,
    input  logic           rst,
    output logic           leds,
    input  logic [11:0]    s_axi_csrs_awaddr,
    input  logic           s_axi_csrs_awvalid,
    output logic           s_axi_csrs_awready,
    input  logic [31:0]    s_axi_csrs_wdata,
    input  logic [3:0]     s_axi_csrs_wstrb,
    input  logic           s_axi_csrs_wvalid,
    output logic           s_axi_csrs_wready,
    output logic [1:0]     s_axi_csrs_bresp,
    output logic           s_axi_csrs_bvalid,
    input  logic           s_axi_csrs_bready,
    input  logic [11:0]    s_axi_csrs_araddr,
    input  logic           s_axi_csrs_arvalid,
    output logic           s_axi_csrs_arready,
    output logic [31:0]    s_axi_csrs_rdata,
    output logic [1:0]     s_axi_csrs_rresp,
    output logic           s_axi_csrs_rvalid,
    input  logic           s_axi_csrs_rready,
    input  logic [16:0]    mem_addr,
    input  logic [1023:0]  mem_din,
    output logic [1023:0]  mem_dout,
    input  logic           mem_en,
    input  logic [127:0]   mem_we
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [2:0] {IDLE, RD, WT, CALC, WR, DONE} state_t;

    function automatic logic [AW-1:0] word_index(input logic [9:0] a);
        return AW'({22'b0, a} % 32'(MEM_DEPTH));
    endfunction

    function automatic logic [31:0] merge_strb(input logic [31:0] old,
                                               input logic [31:0] d,
                                               input logic [3:0]  s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    logic [1023:0] mem [MEM_DEPTH];

    logic            cmd_start;
    logic [31:0]     rx_addr;
    logic [31:0]     tx_addr;
    logic [9:0]      aw_addr;
    logic            aw_full;
    logic [31:0]     w_data;
    logic [3:0]      w_strb;
    logic            w_full;
    state_t          state;
    logic            busy;
    logic            done;
    logic [AW-1:0]   rx_word;
    logic [AW-1:0]   tx_word;
    logic [AW-1:0]   host_word;
    logic [1023:0]   core_rdata;
    logic [1023:0]   result;
    logic            unused_bits;

    assign host_word        = word_index(mem_addr[16:7]);
    assign leds             = done;
    assign s_axi_csrs_bresp = 2'b00;
    assign s_axi_csrs_rresp = 2'b00;
    assign unused_bits      = ^{s_axi_csrs_awaddr[1:0], s_axi_csrs_araddr[1:0], mem_addr[6:0],
                                rx_addr[31:17], rx_addr[6:0], tx_addr[31:17], tx_addr[6:0]};

    // AW and W are captured independently; the register commits once both have arrived.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_axi_csrs_awready <= 1'b0;
            s_axi_csrs_wready  <= 1'b0;
            s_axi_csrs_bvalid  <= 1'b0;
            aw_addr            <= '0;
            aw_full            <= 1'b0;
            w_data             <= '0;
            w_strb             <= '0;
            w_full             <= 1'b0;
            cmd_start          <= 1'b0;
            rx_addr            <= '0;
            tx_addr            <= '0;
        end else begin
            if (s_axi_csrs_awready) begin
                s_axi_csrs_awready <= 1'b0;
                if (s_axi_csrs_awvalid) begin
                    aw_addr <= s_axi_csrs_awaddr[11:2];
                    aw_full <= 1'b1;
                end
            end else if (s_axi_csrs_awvalid && !aw_full && !s_axi_csrs_bvalid) begin
                s_axi_csrs_awready <= 1'b1;
            end

            if (s_axi_csrs_wready) begin
                s_axi_csrs_wready <= 1'b0;
                if (s_axi_csrs_wvalid) begin
                    w_data <= s_axi_csrs_wdata;
                    w_strb <= s_axi_csrs_wstrb;
                    w_full <= 1'b1;
                end
            end else if (s_axi_csrs_wvalid && !w_full && !s_axi_csrs_bvalid) begin
                s_axi_csrs_wready <= 1'b1;
            end

            if (aw_full && w_full && !s_axi_csrs_bvalid) begin
                case (aw_addr)
                    10'd0: if (w_strb[0]) cmd_start <= w_data[0];
                    10'd1: rx_addr <= merge_strb(rx_addr, w_data, w_strb);
                    10'd2: tx_addr <= merge_strb(tx_addr, w_data, w_strb);
                    default: ;
                endcase
                aw_full           <= 1'b0;
                w_full            <= 1'b0;
                s_axi_csrs_bvalid <= 1'b1;
            end else if (s_axi_csrs_bvalid && s_axi_csrs_bready) begin
                s_axi_csrs_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_axi_csrs_arready <= 1'b0;
            s_axi_csrs_rvalid  <= 1'b0;
            s_axi_csrs_rdata   <= '0;
        end else begin
            if (s_axi_csrs_arready) begin
                s_axi_csrs_arready <= 1'b0;
                if (s_axi_csrs_arvalid) begin
                    s_axi_csrs_rvalid <= 1'b1;
                    case (s_axi_csrs_araddr[11:2])
                        10'd0:   s_axi_csrs_rdata <= {30'b0, busy, done};
                        10'd1:   s_axi_csrs_rdata <= rx_addr;
                        10'd2:   s_axi_csrs_rdata <= tx_addr;
                        default: s_axi_csrs_rdata <= '0;
                    endcase
                end
            end else if (s_axi_csrs_rvalid) begin
                if (s_axi_csrs_rready) s_axi_csrs_rvalid <= 1'b0;
            end else if (s_axi_csrs_arvalid) begin
                s_axi_csrs_arready <= 1'b1;
            end
        end
    end

    // Word addresses are latched when leaving IDLE so CSR writes during a run are harmless.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            rx_word <= '0;
            tx_word <= '0;
            result  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_start && !done) begin
                        rx_word <= word_index(rx_addr[16:7]);
                        tx_word <= word_index(tx_addr[16:7]);
                        busy    <= 1'b1;
                        state   <= RD;
                    end
                end
                RD:   state <= WT;
                WT:   state <= CALC;
                CALC: begin
                    result <= core_rdata + 1'b1;
                    state  <= WR;
                end
                WR: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    if (!cmd_start) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Host byte writes come after the core write so the host wins on a shared word.
    always_ff @(posedge clk) begin
        if (state == RD) core_rdata <= mem[rx_word];
        if (state == WR && !rst) mem[tx_word] <= result;
        if (mem_en) begin
            for (int i = 0; i < 128; i++) begin
                if (mem_we[i]) mem[host_word][8*i +: 8] <= mem_din[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_dout <= '0;
        end else if (mem_en) begin
            mem_dout <= mem[host_word];
        end
    end

endmodule

// File: tb/tb_ecdsa_project_wrapper.sv
// Scoreboard bench for ecdsa_project_wrapper: stimulus tasks push expected
// responses, negedge monitors pop and compare against a word-level RAM model.
module tb_ecdsa_project_wrapper;

    localparam int DEPTH = 1024;

    logic           clk = 1'b0;
    logic           rst;
    logic           leds;
    logic [11:0]    s_axi_csrs_awaddr;
    logic           s_axi_csrs_awvalid;
    logic           s_axi_csrs_awready;
    logic [31:0]    s_axi_csrs_wdata;
    logic [3:0]     s_axi_csrs_wstrb;
    logic           s_axi_csrs_wvalid;
    logic           s_axi_csrs_wready;
    logic [1:0]     s_axi_csrs_bresp;
    logic           s_axi_csrs_bvalid;
    logic           s_axi_csrs_bready;
    logic [11:0]    s_axi_csrs_araddr;
    logic           s_axi_csrs_arvalid;
    logic           s_axi_csrs_arready;
    logic [31:0]    s_axi_csrs_rdata;
    logic [1:0]     s_axi_csrs_rresp;
    logic           s_axi_csrs_rvalid;
    logic           s_axi_csrs_rready;
    logic [16:0]    mem_addr;
    logic [1023:0]  mem_din;
    logic [1023:0]  mem_dout;
    logic           mem_en;
    logic [127:0]   mem_we;

    always #5 clk = ~clk;

    ecdsa_project_wrapper #(.MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .leds(leds),
        .s_axi_csrs_awaddr(s_axi_csrs_awaddr), .s_axi_csrs_awvalid(s_axi_csrs_awvalid),
        .s_axi_csrs_awready(s_axi_csrs_awready),
        .s_axi_csrs_wdata(s_axi_csrs_wdata), .s_axi_csrs_wstrb(s_axi_csrs_wstrb),
        .s_axi_csrs_wvalid(s_axi_csrs_wvalid), .s_axi_csrs_wready(s_axi_csrs_wready),
        .s_axi_csrs_bresp(s_axi_csrs_bresp), .s_axi_csrs_bvalid(s_axi_csrs_bvalid),
        .s_axi_csrs_bready(s_axi_csrs_bready),
        .s_axi_csrs_araddr(s_axi_csrs_araddr), .s_axi_csrs_arvalid(s_axi_csrs_arvalid),
        .s_axi_csrs_arready(s_axi_csrs_arready),
        .s_axi_csrs_rdata(s_axi_csrs_rdata), .s_axi_csrs_rresp(s_axi_csrs_rresp),
        .s_axi_csrs_rvalid(s_axi_csrs_rvalid), .s_axi_csrs_rready(s_axi_csrs_rready),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_en(mem_en), .mem_we(mem_we)
    );

    typedef struct {
        bit          check;
        logic [31:0] exp;
        string       name;
    } rd_exp_t;

    typedef struct {
        logic [1023:0] exp;
        string         name;
    } mem_exp_t;

    int            total = 0;
    int            bad = 0;
    rd_exp_t       rd_q[$];
    mem_exp_t      mem_q[$];
    logic [1023:0] model_mem [int];
    logic [31:0]   model_rx;
    logic [31:0]   model_tx;
    bit            mem_rd_seen = 1'b0;

    task automatic checkOutput(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h (low 128 bits)", name, act[127:0], exp[127:0]);
        end
    endtask

    task automatic report_timeout(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: timed out waiting for DUT", name);
    endtask

    function automatic logic [1023:0] rand_word();
        logic [1023:0] r;
        for (int i = 0; i < 32; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] d,
                                                input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // Host-port reads are flagged one cycle later, when mem_dout carries their data.
    always @(posedge clk) mem_rd_seen <= mem_en && (mem_we == '0) && !rst;

    always @(negedge clk) begin
        if (s_axi_csrs_rvalid && s_axi_csrs_rready) begin
            if (rd_q.size() == 0) begin
                report_timeout("unexpected_rvalid");
            end else begin
                rd_exp_t e;
                e = rd_q.pop_front();
                if (e.check) begin
                    checkOutput(e.name, 1024'(s_axi_csrs_rdata), 1024'(e.exp));
                    checkOutput({e.name, "_rresp"}, 1024'(s_axi_csrs_rresp), '0);
                end
            end
        end
        if (s_axi_csrs_bvalid && s_axi_csrs_bready)
            checkOutput("bresp", 1024'(s_axi_csrs_bresp), '0);
        if (mem_rd_seen) begin
            if (mem_q.size() == 0) begin
                report_timeout("unexpected_mem_read");
            end else begin
                mem_exp_t m;
                m = mem_q.pop_front();
                checkOutput(m.name, mem_dout, m.exp);
            end
        end
    end

    task automatic axi_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bit aw_hs, w_hs;
        bit aw_done = 1'b0;
        bit w_done = 1'b0;
        int n = 0;
        @(posedge clk); #1;
        s_axi_csrs_awaddr  = addr;
        s_axi_csrs_awvalid = 1'b1;
        s_axi_csrs_wdata   = data;
        s_axi_csrs_wstrb   = strb;
        s_axi_csrs_wvalid  = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            aw_hs = s_axi_csrs_awvalid && s_axi_csrs_awready;
            w_hs  = s_axi_csrs_wvalid && s_axi_csrs_wready;
            @(posedge clk); #1;
            n++;
            if (aw_hs) begin s_axi_csrs_awvalid = 1'b0; aw_done = 1'b1; end
            if (w_hs)  begin s_axi_csrs_wvalid  = 1'b0; w_done  = 1'b1; end
        end
        s_axi_csrs_awvalid = 1'b0;
        s_axi_csrs_wvalid  = 1'b0;
        n = 0;
        while (!s_axi_csrs_bvalid && n < 20) begin @(posedge clk); #1; n++; end
        if (!(aw_done && w_done) || !s_axi_csrs_bvalid) report_timeout("axi_write");
        case (addr[11:2])
            10'd1: model_rx = merge_bytes(model_rx, data, strb);
            10'd2: model_tx = merge_bytes(model_tx, data, strb);
            default: ;
        endcase
    endtask

    task automatic axi_read(input logic [11:0] addr, input bit check, input logic [31:0] exp,
                            input string name, output logic [31:0] data);
        rd_exp_t e;
        bit hs = 1'b0;
        int n = 0;
        e.check = check;
        e.exp   = exp;
        e.name  = name;
        @(posedge clk); #1;
        s_axi_csrs_araddr  = addr;
        s_axi_csrs_arvalid = 1'b1;
        rd_q.push_back(e);
        while (!hs && n < 20) begin
            hs = s_axi_csrs_arvalid && s_axi_csrs_arready;
            @(posedge clk); #1;
            n++;
        end
        s_axi_csrs_arvalid = 1'b0;
        n = 0;
        while (!s_axi_csrs_rvalid && n < 20) begin @(posedge clk); #1; n++; end
        data = s_axi_csrs_rdata;
        if (!s_axi_csrs_rvalid) begin
            report_timeout({"axi_read_", name});
            void'(rd_q.pop_back());
        end
    endtask

    task automatic read_check(input logic [11:0] addr, input logic [31:0] exp, input string name);
        logic [31:0] d;
        axi_read(addr, 1'b1, exp, name, d);
    endtask

    task automatic mem_write(input int idx, input logic [1023:0] data, input logic [127:0] we);
        logic [1023:0] cur;
        @(posedge clk); #1;
        mem_addr = {idx[9:0], 7'($urandom())};
        mem_din  = data;
        mem_we   = we;
        mem_en   = 1'b1;
        @(posedge clk); #1;
        mem_en = 1'b0;
        mem_we = '0;
        cur = model_mem.exists(idx) ? model_mem[idx] : 'x;
        for (int i = 0; i < 128; i++) if (we[i]) cur[8*i +: 8] = data[8*i +: 8];
        model_mem[idx] = cur;
    endtask

    task automatic mem_read(input int idx, input string name);
        mem_exp_t m;
        m.exp  = model_mem[idx];
        m.name = name;
        mem_q.push_back(m);
        @(posedge clk); #1;
        mem_addr = {idx[9:0], 7'($urandom())};
        mem_we   = '0;
        mem_en   = 1'b1;
        @(posedge clk); #1;
        mem_en = 1'b0;
    endtask

    task automatic wait_done(input string name);
        logic [31:0] d;
        int n = 0;
        do begin
            axi_read(12'h0, 1'b0, '0, "poll", d);
            n++;
        end while (!d[0] && n < 30);
        if (!d[0]) report_timeout(name);
    endtask

    // One complete core run: program addresses, start, wait for done, check, release.
    task automatic applyStimulus(input logic [31:0] rxa, input logic [31:0] txa, input string name);
        int rx_idx, tx_idx;
        logic [1023:0] exp;
        rx_idx = int'(rxa[16:7]) % DEPTH;
        tx_idx = int'(txa[16:7]) % DEPTH;
        exp = model_mem[rx_idx] + 1024'd1;
        axi_write(12'h4, rxa, 4'hF);
        axi_write(12'h8, txa, 4'hF);
        axi_write(12'h0, 32'h1, 4'h1);
        wait_done(name);
        model_mem[tx_idx] = exp;
        read_check(12'h0, 32'h1, {name, "_status_done"});
        checkOutput({name, "_leds_done"}, 1024'(leds), 1024'(1));
        mem_read(tx_idx, {name, "_dst"});
        if (rx_idx != tx_idx) mem_read(rx_idx, {name, "_src"});
        axi_write(12'h0, 32'h0, 4'h1);
        read_check(12'h0, 32'h0, {name, "_status_clear"});
        checkOutput({name, "_leds_clear"}, 1024'(leds), '0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        logic [1023:0] v;
        logic [11:0]   a;
        logic [31:0]   d;
        int            n;

        rst = 1'b1;
        s_axi_csrs_awaddr = '0; s_axi_csrs_awvalid = 1'b0;
        s_axi_csrs_wdata = '0;  s_axi_csrs_wstrb = '0; s_axi_csrs_wvalid = 1'b0;
        s_axi_csrs_bready = 1'b1;
        s_axi_csrs_araddr = '0; s_axi_csrs_arvalid = 1'b0;
        s_axi_csrs_rready = 1'b1;
        mem_addr = '0; mem_din = '0; mem_en = 1'b0; mem_we = '0;
        model_rx = '0;
        model_tx = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_handshakes", 1024'({s_axi_csrs_awready, s_axi_csrs_wready, s_axi_csrs_bvalid,
                                               s_axi_csrs_arready, s_axi_csrs_rvalid}), '0);
        checkOutput("reset_leds", 1024'(leds), '0);
        checkOutput("reset_dout", mem_dout, '0);
        rst = 1'b0;

        read_check(12'h0, 32'h0, "status_after_reset");
        read_check(12'h4, 32'h0, "rxaddr_after_reset");
        read_check(12'h8, 32'h0, "txaddr_after_reset");

        axi_write(12'h4, 32'h100, 4'hF);
        read_check(12'h4, 32'h100, "rxaddr_readback");
        axi_write(12'hC, 32'hFFFF_FFFF, 4'hF);
        read_check(12'hC, 32'h0, "unmapped_read");
        for (int i = 0; i < 6; i++) begin
            a = 12'($urandom_range(1, 2)) << 2;
            axi_write(a, $urandom(), 4'($urandom()));
            read_check(a, (a == 12'h4) ? model_rx : model_tx, "csr_strobe_rand");
        end

        v = '0;
        v[1020] = 1'b1;
        mem_write(2, v, '1);
        mem_write(1, 1024'd2, '1);
        applyStimulus(32'h100, 32'h80, "basic");

        mem_read(2, "hold_prime");
        @(posedge clk); #1;
        mem_addr = 17'h80;
        @(posedge clk); #1;
        checkOutput("dout_hold_when_disabled", mem_dout, model_mem[2]);

        // Carry ripples through every bit; done latency is counted from the write response.
        mem_write(5, '1, '1);
        mem_write(9, rand_word(), '1);
        axi_write(12'h4, 32'd5 << 7, 4'hF);
        axi_write(12'h8, 32'd9 << 7, 4'hF);
        axi_write(12'h0, 32'h1, 4'h1);
        n = 0;
        while (!leds && n < 20) begin @(posedge clk); #1; n++; end
        checkOutput("done_latency_ok", 1024'(n <= 6 && leds), 1024'(1));
        model_mem[9] = '0;
        mem_read(9, "wrap_dst");

        v = rand_word();
        mem_write(9, v, '1);
        repeat (10) @(posedge clk);
        mem_read(9, "no_restart_dst");
        read_check(12'h0, 32'h1, "status_held_done");
        axi_write(12'h0, 32'h0, 4'h1);
        axi_write(12'h0, 32'h1, 4'h1);
        wait_done("rerun");
        model_mem[9] = model_mem[5] + 1024'd1;
        mem_read(9, "rerun_dst");
        axi_write(12'h0, 32'h0, 4'h1);

        mem_write(20, rand_word(), '1);
        mem_write(21, rand_word(), '1);
        mem_write(30, rand_word(), '1);
        axi_write(12'h4, 32'd20 << 7, 4'hF);
        axi_write(12'h8, 32'd21 << 7, 4'hF);
        v = model_mem[20] + 1024'd1;
        axi_write(12'h0, 32'h1, 4'h1);
        axi_write(12'h8, 32'd30 << 7, 4'hF);
        wait_done("busy_csr");
        model_mem[21] = v;
        mem_read(21, "busy_csr_dst");
        mem_read(30, "busy_csr_untouched");
        read_check(12'h8, 32'd30 << 7, "busy_csr_txaddr");
        axi_write(12'h0, 32'h0, 4'h1);

        for (int i = 0; i < 5; i++) begin
            logic [9:0] ri, ti;
            ri = 10'($urandom());
            ti = (i == 0) ? ri : 10'($urandom());
            mem_write(int'(ri), rand_word(), '1);
            mem_write(int'(ri), rand_word(), {$urandom(), $urandom(), $urandom(), $urandom()});
            if (ti != ri) mem_write(int'(ti), rand_word(), '1);
            applyStimulus({15'b0, ri, 7'($urandom())}, {15'b0, ti, 7'($urandom())},
                          (i == 0) ? "in_place" : "rand_op");
        end

        // Reset lands while the core waits on its RAM read.
        mem_write(40, rand_word(), '1);
        mem_write(41, rand_word(), '1);
        axi_write(12'h4, 32'd40 << 7, 4'hF);
        axi_write(12'h8, 32'd41 << 7, 4'hF);
        axi_write(12'h0, 32'h1, 4'h1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_rx = '0;
        model_tx = '0;
        read_check(12'h0, 32'h0, "status_after_abort");
        read_check(12'h4, 32'h0, "rxaddr_after_abort");
        repeat (10) @(posedge clk);
        checkOutput("leds_after_abort", 1024'(leds), '0);
        mem_read(41, "abort_dst_unchanged");

        repeat (3) @(posedge clk);
        axi_read(12'h8, 1'b1, 32'h0, "txaddr_final", d);
        repeat (3) @(posedge clk);
        checkOutput("rd_queue_drained", 1024'(rd_q.size()), '0);
        checkOutput("mem_queue_drained", 1024'(mem_q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
